// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM that sequences fetch, decode, execute,
// memory and writeback over one datapath and one shared memory port.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel_data,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        illegal,
  output logic [31:0] retired,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXEC_R    = 4'd3,
    S_EXEC_I    = 4'd4,
    S_ALU_WB    = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_READ  = 4'd7,
    S_MEM_WB    = 4'd8,
    S_MEM_WRITE = 4'd9,
    S_BRANCH    = 4'd10,
    S_HALT      = 4'd11
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;

  state_t      state_q;
  state_t      state_d;
  logic        ill_q;
  logic [31:0] ret_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_r;
  logic        is_i;
  logic        is_ld;
  logic        is_st;
  logic        is_br;
  logic        known;
  logic        br_legal;
  logic        taken;
  logic        ret_inc;
  logic        ill_set;
  logic        unused_instr;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_ld    = (opcode == OP_LD);
  assign is_st    = (opcode == OP_ST);
  assign is_br    = (opcode == OP_BR);
  assign known    = is_r | is_i | is_ld
                  | is_st | is_br;

  // only beq/bne are wired to the zero-flag compare
  assign br_legal = (funct3[2:1] == 2'b00);
  assign taken    = alu_zero ^ funct3[0];

  assign unused_instr = ^{instr[31:15],
                          instr[11:7]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ill_q   <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      if (ill_set) ill_q <= 1'b1;
      if (ret_inc) ret_q <= ret_q + 32'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        state_d = S_FETCH;
      S_FETCH:
        if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_r:          state_d = S_EXEC_R;
          is_i:          state_d = S_EXEC_I;
          is_ld | is_st: state_d = S_MEM_ADDR;
          is_br:         state_d = S_BRANCH;
          default:       state_d = S_HALT;
        endcase
      end
      S_EXEC_R,
      S_EXEC_I:
        state_d = S_ALU_WB;
      S_ALU_WB:
        state_d = S_FETCH;
      S_MEM_ADDR:
        state_d = is_ld ? S_MEM_READ
                        : S_MEM_WRITE;
      S_MEM_READ:
        if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:
        state_d = S_FETCH;
      S_MEM_WRITE:
        if (mem_ready) state_d = S_FETCH;
      S_BRANCH:
        state_d = br_legal ? S_FETCH
                           : S_HALT;
      S_HALT:
        state_d = S_HALT;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_sel_data = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    alu_src_b    = 1'b0;
    alu_op       = ALU_ADD;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    ret_inc      = 1'b0;
    ill_set      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_DECODE:
        ill_set = ~known;
      S_EXEC_R: begin
        alu_src_b = 1'b0;
        alu_op    = ALU_FN;
      end
      S_EXEC_I: begin
        alu_src_b = 1'b1;
        alu_op    = ALU_FN;
      end
      // hold the EXEC operand select; bit 5 tells R from I
      S_ALU_WB: begin
        alu_src_b = ~instr[5];
        alu_op    = ALU_FN;
        reg_write = 1'b1;
        ret_inc   = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_b = 1'b1;
        alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        mem_req      = 1'b1;
        mem_sel_data = 1'b1;
        alu_src_b    = 1'b1;
        alu_op       = ALU_ADD;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        ret_inc    = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        mem_sel_data = 1'b1;
        alu_src_b    = 1'b1;
        alu_op       = ALU_ADD;
        ret_inc      = mem_ready;
      end
      S_BRANCH: begin
        alu_src_b = 1'b0;
        alu_op    = ALU_SUB;
        pc_write  = br_legal & taken;
        pc_src    = br_legal & taken;
        ret_inc   = br_legal;
        ill_set   = ~br_legal;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  assign illegal = ill_q;
  assign retired = ret_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: expands each instruction into its expected
// per-cycle control trace and compares against multicycle_ctrl.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        alu_zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        mem_sel_data;
  logic        ir_write;
  logic        pc_write;
  logic        pc_src;
  logic        alu_src_b;
  logic [1:0]  alu_op;
  logic        reg_write;
  logic        mem_to_reg;
  logic        illegal;
  logic [31:0] retired;
  logic [3:0]  state;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk),
    .reset(reset),
    .instr(instr),
    .alu_zero(alu_zero),
    .mem_ready(mem_ready),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_sel_data(mem_sel_data),
    .ir_write(ir_write),
    .pc_write(pc_write),
    .pc_src(pc_src),
    .alu_src_b(alu_src_b),
    .alu_op(alu_op),
    .reg_write(reg_write),
    .mem_to_reg(mem_to_reg),
    .illegal(illegal),
    .retired(retired),
    .state(state)
  );

  typedef struct {
    logic [3:0]  st;
    logic [11:0] o;
    logic        rdy;
    logic        az;
  } rec_t;

  rec_t        plan[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model_ret;

  function automatic logic rb();
    return $urandom_range(0, 1) != 0;
  endfunction

  // {req,we,sel,irw,pcw,pcs,srcb,op,rw,m2r,ill}
  function automatic logic [11:0] ov(
    input bit req, we, sel, irw, pcw, pcs, sb,
    input logic [1:0] op,
    input bit rw, m2r, ill);
    return {req, we, sel, irw, pcw, pcs, sb,
            op, rw, m2r, ill};
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic add(input logic [3:0] st,
                     input logic [11:0] o,
                     input logic rdy,
                     input logic az);
    rec_t r;
    r.st = st; r.o = o; r.rdy = rdy; r.az = az;
    plan.push_back(r);
  endtask

  task automatic play(input logic [31:0] ins);
    logic [31:0] got;
    foreach (plan[i]) begin
      instr     = ins;
      mem_ready = plan[i].rdy;
      alu_zero  = plan[i].az;
      @(negedge clk);
      got = {16'b0, state, mem_req, mem_we,
             mem_sel_data, ir_write, pc_write,
             pc_src, alu_src_b, alu_op,
             reg_write, mem_to_reg, illegal};
      check("ctrl", got, {16'b0, plan[i].st, plan[i].o});
      check("retired", retired, model_ret);
      @(posedge clk);
      #1;
    end
    plan.delete();
  endtask

  // one instruction from its first FETCH cycle to its last cycle
  task automatic run_instr(input logic [31:0] ins,
                           input int fw, input int mw,
                           input logic az, input int halt_n);
    logic [6:0] opc;
    logic [2:0] f3;
    bit         legal;
    opc = ins[6:0];
    f3  = ins[14:12];
    legal = 1'b1;
    for (int i = 0; i < fw; i++)
      add(4'd1, ov(1,0,0,0,0,0,0,2'd0,0,0,0), 1'b0, rb());
    add(4'd1, ov(1,0,0,1,1,0,0,2'd0,0,0,0), 1'b1, rb());
    add(4'd2, 12'd0, rb(), rb());
    if (opc == 7'b0110011) begin
      add(4'd3, ov(0,0,0,0,0,0,0,2'd2,0,0,0), rb(), rb());
      add(4'd5, ov(0,0,0,0,0,0,0,2'd2,1,0,0), rb(), rb());
    end else if (opc == 7'b0010011) begin
      add(4'd4, ov(0,0,0,0,0,0,1,2'd2,0,0,0), rb(), rb());
      add(4'd5, ov(0,0,0,0,0,0,1,2'd2,1,0,0), rb(), rb());
    end else if (opc == 7'b0000011) begin
      add(4'd6, ov(0,0,0,0,0,0,1,2'd0,0,0,0), rb(), rb());
      for (int i = 0; i <= mw; i++)
        add(4'd7, ov(1,0,1,0,0,0,1,2'd0,0,0,0),
            i == mw, rb());
      add(4'd8, ov(0,0,0,0,0,0,0,2'd0,1,1,0), rb(), rb());
    end else if (opc == 7'b0100011) begin
      add(4'd6, ov(0,0,0,0,0,0,1,2'd0,0,0,0), rb(), rb());
      for (int i = 0; i <= mw; i++)
        add(4'd9, ov(1,1,1,0,0,0,1,2'd0,0,0,0),
            i == mw, rb());
    end else if (opc == 7'b1100011) begin
      if (f3 == 3'b000 || f3 == 3'b001) begin
        bit tk;
        tk = az ^ f3[0];
        add(4'd10, ov(0,0,0,0,tk,tk,0,2'd1,0,0,0),
            rb(), az);
      end else begin
        legal = 1'b0;
        add(4'd10, ov(0,0,0,0,0,0,0,2'd1,0,0,0),
            rb(), az);
      end
    end else begin
      legal = 1'b0;
    end
    if (!legal)
      for (int i = 0; i < halt_n; i++)
        add(4'd11, ov(0,0,0,0,0,0,0,2'd0,0,0,1), rb(), rb());
    play(ins);
    if (legal) model_ret = model_ret + 32'd1;
  endtask

  // leaves the bench one tick after the edge that enters FETCH
  task automatic do_reset();
    reset     = 1'b1;
    mem_ready = 1'b0;
    alu_zero  = rb();
    @(posedge clk);
    #1;
    reset     = 1'b0;
    model_ret = '0;
    add(4'd0, 12'd0, rb(), rb());
    play(32'h0);
  endtask

  function automatic logic [31:0] rand_instr(input int cls);
    logic [31:0] r;
    r = $urandom;
    case (cls)
      0: return {r[31:7], 7'b0110011};
      1: return {r[31:7], 7'b0010011};
      2: return {r[31:7], 7'b0000011};
      3: return {r[31:7], 7'b0100011};
      default: return {r[31:15], 2'b00, r[12:7], 7'b1100011};
    endcase
  endfunction

  initial begin
    reset     = 1'b1;
    instr     = '0;
    alu_zero  = 1'b0;
    mem_ready = 1'b0;
    model_ret = '0;
    @(posedge clk);
    do_reset();

    run_instr(32'h00500093, 0, 0, 1'b0, 0);
    run_instr(32'h0000B103, 0, 3, 1'b0, 0);
    run_instr(32'h0020B023, 0, 0, 1'b0, 0);
    run_instr(32'h00208463, 0, 0, 1'b1, 0);
    run_instr(32'h00208463, 0, 0, 1'b0, 0);
    run_instr(32'h00209463, 0, 0, 1'b1, 0);
    run_instr(32'h00209463, 0, 0, 1'b0, 0);
    run_instr(32'h002081B3, 2, 0, 1'b0, 0);

    for (int n = 0; n < 200; n++)
      run_instr(rand_instr($urandom_range(0, 4)),
                $urandom_range(0, 3),
                $urandom_range(0, 3),
                rb(), 0);

    force dut.ret_q = 32'hFFFF_FFFF;
    #1;
    release dut.ret_q;
    model_ret = 32'hFFFF_FFFF;
    run_instr(32'h00500093, 0, 0, 1'b0, 0);
    run_instr(32'h0020B023, 1, 1, 1'b0, 0);

    run_instr(32'h0020A463, 0, 0, 1'b1, 5);
    do_reset();
    run_instr(32'h00500093, 1, 0, 1'b0, 0);
    run_instr(32'h0000007F, 0, 0, 1'b0, 20);
    do_reset();

    for (int i = 0; i < 3; i++)
      add(4'd1, ov(1,0,0,0,0,0,0,2'd0,0,0,0), 1'b0, rb());
    play(32'h00500093);
    do_reset();
    run_instr(32'h0000B103, 0, 0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM for the RV64 core, sequencing fetch, decode, execute, memory and writeback over a shared datapath and a single shared instruction/data memory port. It decodes the same opcode classes the immediate generator supports (I-type ALU, load, store, branch) plus R-type. It drives every datapath mux/enable and a request/ready memory handshake. It also keeps a retired-instruction counter and a sticky illegal-opcode flag.

## Interface
- No parameters.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- instr  in  32  instruction register contents, valid from DECODE onward
- alu_zero  in  1  ALU zero flag, combinational from current ALU inputs
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write (store), 0 = read
- mem_sel_data  out  1  address mux: 0 = PC, 1 = ALU result
- ir_write  out  1  load instruction register and old_pc (pre-increment PC)
- pc_write  out  1  update PC
- pc_src  out  1  0 = PC+4, 1 = old_pc + imm (branch adder)
- alu_src_b  out  1  0 = rs2, 1 = imm_gen output
- alu_op  out  2  00 add, 01 sub, 10 decode funct3/funct7
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  writeback mux: 0 = ALU, 1 = memory read data
- illegal  out  1  sticky, set on unsupported opcode
- retired  out  32  retired-instruction count
- state  out  4  current state encoding (debug)

## Operation
- States (encoding): IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, ALU_WB=5, MEM_ADDR=6, MEM_READ=7, MEM_WB=8, MEM_WRITE=9, BRANCH=10, HALT=11.
- IDLE: all outputs 0. Goes to FETCH next cycle.
- FETCH: mem_req=1, mem_sel_data=0, mem_we=0. Stays in FETCH while mem_ready=0. When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, then goes to DECODE.
- DECODE: all enables 0. Decodes instr[6:0]:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - anything else → HALT, and illegal set.
- EXEC_R: alu_src_b=0, alu_op=10, then ALU_WB.
- EXEC_I: alu_src_b=1, alu_op=10, then ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0. ALU controls are held from the preceding EXEC state (alu_src_b equals instr[5]==0). Then FETCH.
- MEM_ADDR: alu_src_b=1, alu_op=00. Goes to MEM_READ if opcode is a load, MEM_WRITE if a store.
- MEM_READ: mem_req=1, mem_sel_data=1, mem_we=0, ALU controls held. Waits for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, then FETCH.
- MEM_WRITE: mem_req=1, mem_we=1, mem_sel_data=1, ALU controls held. Waits for mem_ready, then FETCH.
- BRANCH: alu_src_b=0, alu_op=01.
  - Supported funct3: 000 (beq) and 001 (bne).
  - taken = alu_zero XOR funct3[0]. If taken: pc_write=1, pc_src=1.
  - Then FETCH.
  - Any other funct3 → HALT, illegal set, no PC write.
- HALT: all outputs 0 except illegal=1. Stays in HALT until reset.
- retired increments by 1 on the last cycle of each instruction: ALU_WB, MEM_WB, the MEM_WRITE cycle with mem_ready=1, and a legal BRANCH. Wraps from 0xFFFFFFFF to 0. Not incremented for illegal instructions.
- mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.

## Timing
- Reset: while reset=1 at a clock edge, state←IDLE, illegal←0, retired←0. From the following cycle all outputs are 0, state=0.
- Reset asserted mid-access: the state goes to IDLE at that edge and mem_req drops in the same cycle the IDLE state is visible. The pending memory access is abandoned; no PC or IR update.
- Outputs are decoded from the state register. Only ir_write, pc_write (FETCH) and retired increment (MEM_WRITE) are additionally qualified by mem_ready. BRANCH pc_write is qualified by alu_zero.
- mem_req, mem_we and mem_sel_data stay stable while waiting for mem_ready; the request is never withdrawn before mem_ready.
- Cycles with zero-wait memory (mem_ready=1 on the first request cycle), counted from entering FETCH:
  - R/I: 4
  - load: 5
  - store: 4
  - branch: 3
- Each memory wait cycle adds 1.
- After reset deasserts there is 1 IDLE cycle before the first FETCH.

## Test plan
- Reset, then mem_ready tied to 1, instr=0x00500093 (addi): state 0→1→2→4→5→1; reg_write=1 only in state 5; retired=1 after 5 cycles.
- Load 0x0000B103 with mem_ready low for 3 cycles in MEM_READ: mem_req/mem_sel_data held for 4 cycles; MEM_WB has mem_to_reg=1; total 8 cycles; retired +1.
- Store 0x0020B023: mem_we=1 only in MEM_WRITE; no reg_write asserted anywhere; retired +1 on the mem_ready cycle.
- beq 0x00208463 with alu_zero=1 → pc_write=1, pc_src=1 in BRANCH. Repeat with alu_zero=0 → pc_write=0. Repeat as bne (funct3=001) → the results invert.
- instr=0x0000007F: DECODE→HALT, illegal=1, retired unchanged, and it stays in HALT for 20 cycles. Then reset → IDLE with illegal=0.
- Assert reset during a FETCH wait (mem_ready=0): the next cycle shows state=0, mem_req=0, with no ir_write or pc_write. Preload retired=0xFFFFFFFF via 2^32−1 forced instructions (or a bench force) and confirm the next retire yields 0.
